// File: rtl/mem_dump.sv
// rtl/mem_dump.sv - RAM window read-out engine streaming a framed, checksummed byte stream
module mem_dump #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done
);

    localparam int NB = DATA_W / 8;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SYNC = 3'd1;
    localparam logic [2:0] S_RD   = 3'd2;
    localparam logic [2:0] S_LAT  = 3'd3;
    localparam logic [2:0] S_BYTE = 3'd4;
    localparam logic [2:0] S_CSUM = 3'd5;
    localparam logic [2:0] S_FIN  = 3'd6;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    logic [2:0]        state;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   idx;
    logic [DATA_W-1:0] shreg;
    logic [BW-1:0]     bidx;
    logic [7:0]        csum;

    logic accept;
    logic last_byte;
    logic last_word;

    assign accept    = tx_valid && tx_ready;
    assign last_byte = (bidx == BW'(NB - 1));
    assign last_word = ((idx + (ADDR_W+1)'(1)) == count_q);

    // Frame sequencing: sync byte, per-word read/latch/serialise, checksum, done pulse.
    // Outputs are decoded from state so an asynchronous reset clears them immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            base_q  <= '0;
            count_q <= '0;
            idx     <= '0;
            shreg   <= '0;
            bidx    <= '0;
            csum    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        base_q  <= base_addr;
                        count_q <= word_count;
                        idx     <= '0;
                        csum    <= '0;
                        state   <= S_SYNC;
                    end
                end
                S_SYNC: begin
                    if (accept) begin
                        state <= (count_q == '0) ? S_CSUM : S_RD;
                    end
                end
                S_RD: begin
                    state <= S_LAT;
                end
                S_LAT: begin
                    shreg <= mem_rdata;
                    bidx  <= '0;
                    state <= S_BYTE;
                end
                S_BYTE: begin
                    if (accept) begin
                        csum  <= csum ^ shreg[7:0];
                        shreg <= shreg >> 8;
                        bidx  <= bidx + BW'(1);
                        if (last_byte) begin
                            idx   <= idx + (ADDR_W+1)'(1);
                            state <= last_word ? S_CSUM : S_RD;
                        end
                    end
                end
                S_CSUM: begin
                    if (accept) begin
                        state <= S_FIN;
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Output decode; the address wraps naturally through the ADDR_W-bit add.
    always_comb begin
        mem_re   = 1'b0;
        mem_addr = '0;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            S_SYNC: begin
                tx_valid = 1'b1;
                tx_data  = SYNC_BYTE;
                busy     = 1'b1;
            end
            S_RD: begin
                mem_re   = 1'b1;
                mem_addr = base_q + idx[ADDR_W-1:0];
                busy     = 1'b1;
            end
            S_LAT: begin
                busy = 1'b1;
            end
            S_BYTE: begin
                tx_valid = 1'b1;
                tx_data  = shreg[7:0];
                busy     = 1'b1;
            end
            S_CSUM: begin
                tx_valid = 1'b1;
                tx_data  = csum;
                busy     = 1'b1;
            end
            S_FIN: begin
                done = 1'b1;
            end
            default: begin
                mem_re = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_dump.sv
// tb/tb_mem_dump.sv - randomized self-checking bench for mem_dump against a frame-level model
module tb_mem_dump;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  base_addr = '0;
    logic [8:0]  word_count = '0;
    logic        mem_re;
    logic [7:0]  mem_addr;
    logic [15:0] mem_rdata = '0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        busy;
    logic        done;

    mem_dump #(.DATA_W(16), .ADDR_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .mem_re     (mem_re),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    logic [15:0] ram [256];
    always @(posedge clk) if (mem_re) mem_rdata <= ram[mem_addr];

    bit rand_ready = 1'b0;
    always @(posedge clk) begin
        #1;
        tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    logic [7:0] got_q[$];
    logic [7:0] addr_q[$];
    int         done_cnt = 0;
    bit         hold_pend = 1'b0;
    logic [7:0] hold_data = '0;

    always @(negedge clk) begin
        if (reset) begin
            if (tx_valid && tx_ready) got_q.push_back(tx_data);
            if (mem_re) begin
                addr_q.push_back(mem_addr);
                check("mem_re_vs_tx_valid", {31'd0, tx_valid}, 32'd0);
            end
            if (done) done_cnt++;
            if (hold_pend) check("hold_stable", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, hold_data});
            hold_pend = tx_valid && !tx_ready;
            hold_data = tx_data;
        end else begin
            hold_pend = 1'b0;
        end
    end

    task automatic run_frame(input string tag, input logic [7:0] b, input logic [8:0] c,
                             input bit rnd, input bit restart, input bit start_at_done);
        logic [7:0]  exp_q[$];
        logic [7:0]  exp_a[$];
        logic [7:0]  cs;
        logic [7:0]  a;
        logic [15:0] w;
        int          n;
        int          m;
        bit          seen;
        cs = 8'h00;
        exp_q.push_back(8'hA5);
        for (int k = 0; k < int'(c); k++) begin
            a = b + 8'(k);
            w = ram[a];
            exp_a.push_back(a);
            exp_q.push_back(w[7:0]);
            exp_q.push_back(w[15:8]);
            cs = cs ^ w[7:0] ^ w[15:8];
        end
        exp_q.push_back(cs);

        got_q.delete();
        addr_q.delete();
        done_cnt = 0;
        rand_ready = rnd;
        @(posedge clk); #1;
        base_addr = b;
        word_count = c;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 6000) begin
            @(negedge clk);
            n++;
            if (restart && n == 4) begin
                start = 1'b1;
                base_addr = b + 8'h40;
                word_count = 9'd7;
            end else if (restart && n == 5) begin
                start = 1'b0;
            end
            if (done) begin
                seen = 1'b1;
                check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
            end else begin
                check({tag, "_busy"}, {31'd0, busy}, 32'd1);
            end
        end
        check({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
        if (!rnd) check({tag, "_latency"}, n, 3 + 4 * int'(c));
        if (start_at_done) begin
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            repeat (4) begin
                @(negedge clk);
                check({tag, "_ignored_busy"}, {31'd0, busy}, 32'd0);
                check({tag, "_ignored_valid"}, {31'd0, tx_valid}, 32'd0);
            end
        end else begin
            @(negedge clk);
            check({tag, "_done_low"}, {31'd0, done}, 32'd0);
        end
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_nbytes"}, got_q.size(), exp_q.size());
        m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < m; i++) check({tag, "_byte"}, {24'd0, got_q[i]}, {24'd0, exp_q[i]});
        check({tag, "_nreads"}, addr_q.size(), exp_a.size());
        m = (addr_q.size() < exp_a.size()) ? addr_q.size() : exp_a.size();
        for (int i = 0; i < m; i++) check({tag, "_addr"}, {24'd0, addr_q[i]}, {24'd0, exp_a[i]});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < 256; i++) ram[i] = 16'($urandom);

        #13;
        check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_mem_re", {31'd0, mem_re}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        ram[0] = 16'h1234;
        ram[1] = 16'hABCD;
        run_frame("t1", 8'h00, 9'd2, 1'b0, 1'b0, 1'b0);
        run_frame("t2", 8'h00, 9'd2, 1'b1, 1'b0, 1'b0);

        ram[8'hFF] = 16'h0001;
        ram[8'h00] = 16'h0100;
        run_frame("t3", 8'hFF, 9'd2, 1'b0, 1'b0, 1'b0);

        run_frame("t4", 8'h37, 9'd0, 1'b0, 1'b0, 1'b0);

        run_frame("t5a", 8'h20, 9'd1, 1'b0, 1'b1, 1'b1);
        run_frame("t5b", 8'h21, 9'd1, 1'b0, 1'b0, 1'b0);

        for (int k = 0; k < 6; k++)
            run_frame("rnd", 8'($urandom), 9'($urandom_range(1, 12)), 1'b1, 1'b0, 1'b0);

        run_frame("full", 8'($urandom), 9'd256, 1'b0, 1'b0, 1'b0);

        got_q.delete();
        rand_ready = 1'b0;
        @(posedge clk); #1;
        base_addr = 8'h10;
        word_count = 9'd4;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (!(got_q.size() >= 2 && tx_valid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t6_pre_valid", {31'd0, tx_valid}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("t6_valid_drop", {31'd0, tx_valid}, 32'd0);
        check("t6_busy_drop", {31'd0, busy}, 32'd0);
        check("t6_mem_re_drop", {31'd0, mem_re}, 32'd0);
        #20;
        reset = 1'b1;
        @(negedge clk);
        check("t6_idle_after", {31'd0, tx_valid | busy}, 32'd0);
        run_frame("t6", 8'h10, 9'd4, 1'b1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
